// File: rtl/wb_rr_arbiter_ctrl.sv
// wb_rr_arbiter_ctrl -- round-robin bus arbiter for N_REQ Wishbone masters
// sharing one slave-side bus.
//
// A master keeps the bus for as long as it holds CYC. After it releases, the
// bus is idle for one turnaround cycle. The next grant goes to the first
// requester found searching upward from the last granted master.
//
// Optional build macro WB_ARB_TIMEOUT_EN adds a watchdog. If the granted
// master's strobe stalls for TIMEOUT_CYCLES cycles, the arbiter emits a
// one-cycle to_err pulse and keeps the grant. When the macro is undefined,
// to_err is tied low.
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset
//   m_cyc      [N_REQ] CYC of each master (request)
//   s_stb      STB of the muxed slave-side bus
//   s_ack      slave ACK
//   s_err      slave ERR
//   gnt        [N_REQ] registered one-hot grant
//   gnt_valid  OR of gnt
//   gnt_id     index of granted master, 0 when none
//   to_err     one-cycle timeout ERR pulse
//
// state | meaning
// IDLE  | no grant; pick next requester round-robin
// GRANT | bus owned by gnt_id until its CYC drops
// TURN  | one-cycle bus turnaround with gnt=0

module wb_rr_arbiter_ctrl #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] m_cyc,
    input  logic             s_stb,
    input  logic             s_ack,
    input  logic             s_err,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [GW-1:0]    gnt_id,
    output logic             to_err
);

    if (N_REQ < 1 || N_REQ > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("wb_rr_arbiter_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [GW-1:0]    id_nxt;
    logic [GW-1:0]    last_id, last_nxt;
    logic [GW-1:0]    pick;

    // Search upward from last_id+1, wrapping, so the last owner is checked last.
    always_comb begin
        int idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_id) + k) % N_REQ;
            if (!found && m_cyc[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        last_nxt  = last_id;
        case (state)
            IDLE: begin
                if (|m_cyc) begin
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    id_nxt        = pick;
                    last_nxt      = pick;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                // Release is decided on CYC alone; a same-cycle ACK does not extend ownership.
                if (!m_cyc[gnt_id]) begin
                    gnt_nxt   = '0;
                    id_nxt    = '0;
                    state_nxt = TURN;
                end
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                id_nxt    = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            last_id <= GW'(N_REQ - 1);
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= id_nxt;
            last_id <= last_nxt;
        end
    end

    assign gnt_valid = |gnt;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_err_q;
    logic        stall;

    assign stall = (state == GRANT) && s_stb && !s_ack && !s_err;

    // The counter holds the number of stalled cycles already seen. When it
    // reaches TIMEOUT_CYCLES-1 and the stall continues, the next cycle carries
    // the pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= 1'b0;
            if (!stall) begin
                to_cnt <= '0;
            end else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                to_cnt   <= '0;
                to_err_q <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
        end
    end

    assign to_err = to_err_q;
`else
    logic unused_bus;
    assign unused_bus = s_stb ^ s_ack ^ s_err;
    assign to_err     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter_ctrl.sv
// Testbench for wb_rr_arbiter_ctrl with N_REQ=3 and TIMEOUT_CYCLES=4.
// Table-driven grant/release/reset vectors, then hand-written burst and
// stall sequences.
module tb_wb_rr_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] m_cyc;
    logic       s_stb, s_ack, s_err;
    logic [2:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       to_err;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_ctrl #(.N_REQ(3), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn), .m_cyc(m_cyc), .s_stb(s_stb), .s_ack(s_ack),
        .s_err(s_err), .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
        .to_err(to_err)
    );

    typedef struct packed {
        logic       rstn;
        logic [2:0] m;
        logic [2:0] eg;
        logic [1:0] eid;
    } vec_t;

    vec_t vec [25];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] eg, input logic [1:0] eid,
                       input logic eerr);
        n_vec++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== (|eg) || to_err !== eerr) begin
            n_miss++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b to_err=%b, want gnt=%b id=%0d valid=%b to_err=%b",
                     name, gnt, gnt_id, gnt_valid, to_err, eg, eid, |eg, eerr);
        end
    endtask

    initial begin
        // {rstn, m_cyc, expected gnt, expected gnt_id} after the edge
        vec[0]  = '{1'b0, 3'b000, 3'b000, 2'd0};  // reset
        vec[1]  = '{1'b1, 3'b111, 3'b001, 2'd0};  // master 0 wins first
        vec[2]  = '{1'b1, 3'b111, 3'b001, 2'd0};  // held
        vec[3]  = '{1'b1, 3'b110, 3'b000, 2'd0};  // release -> TURN
        vec[4]  = '{1'b1, 3'b110, 3'b000, 2'd0};  // TURN -> IDLE
        vec[5]  = '{1'b1, 3'b111, 3'b010, 2'd1};  // 1 follows 0 even though 0 requests
        vec[6]  = '{1'b1, 3'b101, 3'b000, 2'd0};
        vec[7]  = '{1'b1, 3'b101, 3'b000, 2'd0};
        vec[8]  = '{1'b1, 3'b101, 3'b100, 2'd2};
        vec[9]  = '{1'b1, 3'b001, 3'b000, 2'd0};
        vec[10] = '{1'b1, 3'b011, 3'b000, 2'd0};  // requests during TURN not granted
        vec[11] = '{1'b1, 3'b011, 3'b001, 2'd0};  // wrap to 0
        vec[12] = '{1'b1, 3'b010, 3'b000, 2'd0};
        vec[13] = '{1'b1, 3'b010, 3'b000, 2'd0};
        vec[14] = '{1'b1, 3'b010, 3'b010, 2'd1};
        vec[15] = '{1'b0, 3'b010, 3'b000, 2'd0};  // reset mid-grant
        vec[16] = '{1'b1, 3'b000, 3'b000, 2'd0};
        vec[17] = '{1'b1, 3'b100, 3'b100, 2'd2};
        vec[18] = '{1'b0, 3'b100, 3'b000, 2'd0};  // reset during grant to 2
        vec[19] = '{1'b1, 3'b101, 3'b001, 2'd0};  // master 0 first after reset
        vec[20] = '{1'b1, 3'b101, 3'b001, 2'd0};
        vec[21] = '{1'b1, 3'b100, 3'b000, 2'd0};
        vec[22] = '{1'b1, 3'b100, 3'b000, 2'd0};
        vec[23] = '{1'b1, 3'b100, 3'b100, 2'd2};
        vec[24] = '{1'b1, 3'b000, 3'b000, 2'd0};

        rstn = 1'b0; m_cyc = '0; s_stb = 1'b0; s_ack = 1'b0; s_err = 1'b0;

        for (int i = 0; i < 25; i++) begin
            rstn  = vec[i].rstn;
            m_cyc = vec[i].m;
            tick();
            chk($sformatf("vec%0d", i), vec[i].eg, vec[i].eid, 1'b0);
        end

        // Burst: master 0 owns the bus for 8 acked beats while master 2 waits.
        m_cyc = 3'b000;
        tick();
        chk("idle_before_burst", 3'b000, 2'd0, 1'b0);
        m_cyc = 3'b101;
        tick();
        chk("burst_grant", 3'b001, 2'd0, 1'b0);
        s_stb = 1'b1; s_ack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            tick();
            chk($sformatf("burst_beat%0d", b), 3'b001, 2'd0, 1'b0);
        end
        m_cyc = 3'b100;  // master 0 drops CYC in the same cycle as its last ACK
        tick();
        chk("burst_release", 3'b000, 2'd0, 1'b0);
        s_stb = 1'b0; s_ack = 1'b0;
        tick();
        chk("burst_turn", 3'b000, 2'd0, 1'b0);
        tick();
        chk("burst_next_m2", 3'b100, 2'd2, 1'b0);

        // Stall: master 2 strobes with no response.
        s_stb = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
`ifdef WB_ARB_TIMEOUT_EN
            chk($sformatf("stall%0d", k), 3'b100, 2'd2, (k % 4) == 0);
`else
            chk($sformatf("stall%0d", k), 3'b100, 2'd2, 1'b0);
`endif
        end
        s_ack = 1'b1;
        tick();
        chk("stall_ack", 3'b100, 2'd2, 1'b0);
        s_ack = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("restall%0d", k), 3'b100, 2'd2, 1'b0);
        end
        s_stb = 1'b0;
        m_cyc = 3'b000;
        tick();
        chk("final_release", 3'b000, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter_ctrl.md
WB_RR_ARBITER_CTRL -- requirements
Module: wb_rr_arbiter_ctrl

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of Wishbone masters (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: stalled-strobe cycles before a forced ERR (2..65535).
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port m_cyc, input, N_REQ: CYC of each master; a bus request when high.
REQ-006 SHALL have port s_stb, input, 1: STB of the muxed slave-side bus.
REQ-007 SHALL have port s_ack, input, 1: ACK returned by the addressed slave.
REQ-008 SHALL have port s_err, input, 1: ERR returned by the addressed slave.
REQ-009 SHALL have port gnt, output, N_REQ: one-hot grant, registered.
REQ-010 SHALL have port gnt_valid, output, 1: OR of gnt.
REQ-011 SHALL have port gnt_id, output, max(1,$clog2(N_REQ)): index of granted master; 0 when none.
REQ-012 SHALL have port to_err, output, 1: one-cycle timeout ERR pulse, OR-ed by the fabric into the granted master's ERR.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, TURN.
REQ-014 IDLE: if |m_cyc, SHALL grant the first requester found searching upward from last_id+1, wrapping modulo N_REQ; gnt/gnt_id SHALL be valid on the next edge; state -> GRANT.
REQ-015 last_id SHALL update to the new gnt_id on every grant.
REQ-016 GRANT: SHALL hold gnt unchanged while m_cyc[gnt_id]=1, regardless of other requests, burst length or CTI.
REQ-017 GRANT: when m_cyc[gnt_id]=0 (even in the same cycle as s_ack), SHALL clear gnt on the next edge; state -> TURN.
REQ-018 TURN: SHALL hold gnt=0 for exactly one cycle (bus turnaround); state -> IDLE, so a re-grant is seen 2 cycles after release.
REQ-019 Simultaneous requests in IDLE SHALL resolve strictly by the round-robin order of REQ-014; no master shall wait more than N_REQ-1 grants.
REQ-020 A master with m_cyc=1 only during TURN SHALL NOT be granted until the IDLE decision.
REQ-021 For N_REQ=1, gnt_id SHALL be constant 0 and round-robin logic reduces to grant/release.
REQ-022 gnt_valid SHALL equal |gnt in every cycle; gnt SHALL never have more than one bit set.

Reset
REQ-023 With rstn=0 at a rising edge: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, to_err=0, timeout counter=0, last_id=N_REQ-1 (master 0 wins first).
REQ-024 Reset asserted mid-grant SHALL drop gnt on that edge with no TURN cycle; no to_err shall be generated.

Configuration
REQ-025 Macro WB_ARB_TIMEOUT_EN SHALL compile the timeout watchdog in or out.
REQ-026 Defined: 16-bit counter counts cycles in GRANT with s_stb=1 and s_ack=0 and s_err=0; cleared on s_ack, s_err, s_stb=0 or leaving GRANT.
REQ-027 Defined: when counter reaches TIMEOUT_CYCLES-1 with the stall persisting, to_err SHALL be 1 on the next cycle for exactly one cycle and the counter SHALL reset to 0; the grant is retained.
REQ-028 Not defined: to_err SHALL be tied 0, no counter logic, TIMEOUT_CYCLES ignored; all other behaviour unchanged.

Verification
REQ-029 Reset, then m_cyc=3'b111 held -> grants in order 0,1,2,0 as each master drops cyc after one ack; each re-grant 2 cycles after release.
REQ-030 m_cyc=3'b010 rising at cycle 10 in IDLE -> gnt=3'b010, gnt_id=1 at cycle 11; m_cyc[1] falls at 20 -> gnt=0 at 21, TURN at 21, IDLE at 22.
REQ-031 Master 0 granted, master 2 requests throughout an 8-beat burst of master 0 -> gnt stays 3'b001 for all 8 acks; master 2 granted 2 cycles after master 0 releases.
REQ-032 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, granted master asserts s_stb with no ack -> to_err=1 for one cycle on the 5th stalled cycle, gnt retained; without macro -> to_err never asserts.
REQ-033 rstn=0 during grant to master 2 -> gnt=0, gnt_id=0 next edge; after release, m_cyc=3'b101 -> master 0 granted first.
